// File: rtl/uart_cmd_parser_if.sv
// Byte-stream and memory-port bundle between the host UART, the command parser
// and the 8755 programming logic. The parser drives the master side.
interface uart_cmd_parser_if;
  logic [7:0]  rx_data;
  logic        new_rx_data;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        mem_req;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    input  rx_data, new_rx_data, tx_busy, mem_rdata, mem_ack,
    output tx_data, new_tx_data, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, new_rx_data, tx_busy, mem_rdata, mem_ack,
    input  tx_data, new_tx_data, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Host packet framer for the PGM8755: checks CMD/ADDR/LEN/CSUM, buffers write
// payload until the checksum verifies, then runs the memory port and replies.
module uart_cmd_parser #(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  uart_cmd_parser_if.master bus
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [7:0] CMD_PING = 8'h50;
  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, LEN, DATA, CSUM, MEM, SEND, RESP
  } state_t;

  state_t             state;
  logic [7:0]         cmd;
  logic [7:0]         sum;
  logic [10:0]        addr;
  logic [CNT_W-1:0]   len;
  logic [CNT_W-1:0]   cnt;
  logic [TMO_W-1:0]   tmo;
  logic [7:0]         resp_byte;
  logic               tx_guard;
  logic [7:0]         rd_byte;
  logic [7:0]         wbuf [MAX_LEN];

  logic [7:0] sum_nxt;
  logic       is_wr;
  logic       in_frame;
  logic       tmo_hit;
  logic       tx_ready;
  logic       last_xfer;

  assign sum_nxt   = sum + bus.rx_data;
  assign is_wr     = (cmd == CMD_WR);
  assign in_frame  = (state == ADDR_HI) || (state == ADDR_LO) || (state == LEN) ||
                     (state == DATA) || (state == CSUM);
  assign tmo_hit   = in_frame && !bus.new_rx_data && (tmo == TMO_LAST);
  // tx_busy is not trusted during the pulse cycle and the guard cycle after it.
  assign tx_ready  = !bus.tx_busy && !bus.new_tx_data && !tx_guard;
  assign last_xfer = (cnt == len - 1'b1);

  // Payload storage and captured read data carry no reset.
  always_ff @(posedge clk) begin
    if (state == DATA && bus.new_rx_data)
      wbuf[cnt[IDX_W-1:0]] <= bus.rx_data;
    if (state == MEM && bus.mem_req && bus.mem_ack)
      rd_byte <= bus.mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cmd             <= '0;
      sum             <= '0;
      addr            <= '0;
      len             <= '0;
      cnt             <= '0;
      tmo             <= '0;
      resp_byte       <= '0;
      tx_guard        <= 1'b0;
      bus.tx_data     <= '0;
      bus.new_tx_data <= 1'b0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
    end else begin
      bus.new_tx_data <= 1'b0;
      tx_guard        <= bus.new_tx_data;
      tmo             <= (in_frame && !bus.new_rx_data) ? tmo + 1'b1 : '0;

      unique case (state)
        IDLE: if (bus.new_rx_data) begin
          cmd <= bus.rx_data;
          sum <= bus.rx_data;
          if (bus.rx_data == CMD_PING)
            state <= CSUM;
          else if (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD)
            state <= ADDR_HI;
          else begin
            resp_byte <= NAK;
            state     <= RESP;
          end
        end

        ADDR_HI: if (bus.new_rx_data) begin
          sum <= sum_nxt;
          if (bus.rx_data[7:3] != 5'd0) begin
            resp_byte <= NAK;
            state     <= RESP;
          end else begin
            addr[10:8] <= bus.rx_data[2:0];
            state      <= ADDR_LO;
          end
        end

        ADDR_LO: if (bus.new_rx_data) begin
          sum       <= sum_nxt;
          addr[7:0] <= bus.rx_data;
          state     <= LEN;
        end

        LEN: if (bus.new_rx_data) begin
          sum <= sum_nxt;
          if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
            resp_byte <= NAK;
            state     <= RESP;
          end else begin
            len   <= bus.rx_data[CNT_W-1:0];
            cnt   <= '0;
            state <= is_wr ? DATA : CSUM;
          end
        end

        DATA: if (bus.new_rx_data) begin
          sum <= sum_nxt;
          if (last_xfer) begin
            cnt   <= '0;
            state <= CSUM;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CSUM: if (bus.new_rx_data) begin
          if (sum_nxt == 8'h00) begin
            resp_byte <= ACK;
            cnt       <= '0;
            state     <= (cmd == CMD_PING) ? RESP : MEM;
          end else begin
            resp_byte <= NAK;
            state     <= RESP;
          end
        end

        // One request at a time; mem_req stays low for the cycle after each ack.
        MEM: begin
          if (!bus.mem_req) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= is_wr;
            bus.mem_addr  <= addr;
            bus.mem_wdata <= is_wr ? wbuf[cnt[IDX_W-1:0]] : 8'h00;
          end else if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            addr        <= addr + 11'd1;
            cnt         <= cnt + 1'b1;
            if (is_wr) begin
              if (last_xfer)
                state <= RESP;
            end else if (tx_ready) begin
              bus.new_tx_data <= 1'b1;
              bus.tx_data     <= bus.mem_rdata;
              state           <= last_xfer ? RESP : MEM;
            end else begin
              state <= SEND;
            end
          end
        end

        SEND: if (tx_ready) begin
          bus.new_tx_data <= 1'b1;
          bus.tx_data     <= rd_byte;
          state           <= (cnt == len) ? RESP : MEM;
        end

        RESP: if (tx_ready) begin
          bus.new_tx_data <= 1'b1;
          bus.tx_data     <= resp_byte;
          state           <= IDLE;
        end

        default: state <= IDLE;
      endcase

      if (tmo_hit) begin
        resp_byte <= NAK;
        state     <= RESP;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a UART busy model and a delayed-ack
// memory model that logs every completed request.
module tb_uart_cmd_parser;
  localparam int TXB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_parser_if bus();

  uart_cmd_parser #(.MAX_LEN(16), .TIMEOUT_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, last_rx_cyc = 0, last_tx_cyc = -1000;
  int busy_cnt = 0, wcnt = 0, mem_delay = 0, rd_idx = 0;
  int gap_err = 0, stab_err = 0, hold_err = 0, req_cycles = 0;
  logic [19:0] lat;
  logic [7:0]  txq[$];
  int          tx_cyc[$];
  logic [19:0] memq[$];
  int          ack_cyc[$];
  int          req_cyc[$];
  logic [7:0]  rdq[$];

  // UART transmitter and memory models, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      busy_cnt      = 0;
      bus.tx_busy   = 1'b0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      wcnt          = 0;
    end else begin
      if (bus.new_rx_data) last_rx_cyc = cyc;
      if (busy_cnt > 0) busy_cnt--;
      if (bus.new_tx_data) begin
        txq.push_back(bus.tx_data);
        tx_cyc.push_back(cyc);
        if (cyc - last_tx_cyc < TXB + 1) gap_err++;
        last_tx_cyc = cyc;
        busy_cnt = TXB;
      end
      bus.tx_busy = (busy_cnt != 0);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        if (bus.mem_req) hold_err++;
      end else if (bus.mem_req) begin
        req_cycles++;
        if (wcnt == 0) begin
          lat = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
          req_cyc.push_back(cyc);
        end else if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== lat) begin
          stab_err++;
        end
        if (wcnt >= mem_delay) begin
          bus.mem_ack   = 1'b1;
          memq.push_back(lat);
          ack_cyc.push_back(cyc);
          bus.mem_rdata = (rd_idx < rdq.size()) ? rdq[rd_idx] : 8'h00;
          rd_idx++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data     = b;
    bus.new_rx_data = 1'b1;
    @(posedge clk); #1;
    bus.new_rx_data = 1'b0;
  endtask

  task automatic send_pkt(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_byte(v[8*i +: 8]);
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && txq.size() < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    txq.delete(); tx_cyc.delete(); memq.delete(); ack_cyc.delete(); req_cyc.delete();
    rdq.delete();
    rd_idx = 0; gap_err = 0; stab_err = 0; hold_err = 0; req_cycles = 0;
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] d;
    int dly;
    rst = 1'b0;
    bus.rx_data = 8'h00;
    bus.new_rx_data = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", {2'b0, bus.tx_data, bus.new_tx_data, bus.mem_req, bus.mem_we,
                          bus.mem_addr, bus.mem_wdata}, 32'h0);
    rst = 1'b1;
    settle(3);

    // Ping
    clear();
    send_pkt(64'h50B0, 2);
    wait_tx(1, 50); settle(20);
    chk("ping_count", txq.size(), 1);
    chk("ping_byte", txq[0], 8'h06);
    chk("ping_latency", tx_cyc[0] - last_rx_cyc, 2);
    chk("ping_no_req", req_cycles, 0);

    // Write with slow ack
    clear(); mem_delay = 10;
    send_pkt(64'h57012302AA5584, 7);
    wait_tx(1, 300); settle(20);
    chk("wr_count", memq.size(), 2);
    chk("wr_txn0", memq[0], {1'b1, 11'h123, 8'hAA});
    chk("wr_txn1", memq[1], {1'b1, 11'h124, 8'h55});
    chk("wr_req_latency", req_cyc[0] - last_rx_cyc, 2);
    chk("wr_stable", stab_err, 0);
    chk("wr_req_drop", hold_err, 0);
    chk("wr_resp_count", txq.size(), 1);
    chk("wr_resp_byte", txq[0], 8'h06);

    // Write with bad checksum
    clear(); mem_delay = 0;
    send_pkt(64'h57012302AA5585, 7);
    wait_tx(1, 100); settle(20);
    chk("badcs_byte", txq[0], 8'h15);
    chk("badcs_no_req", req_cycles, 0);

    // Read across the 0x7FF wrap
    clear(); mem_delay = 2;
    rdq.push_back(8'h11); rdq.push_back(8'h22);
    send_pkt(64'h5207FF02A6, 5);
    wait_tx(3, 300); settle(20);
    chk("rd_count", memq.size(), 2);
    chk("rd_txn0", memq[0][19:8], {1'b0, 11'h7FF});
    chk("rd_txn1", memq[1][19:8], {1'b0, 11'h000});
    chk("rd_tx_count", txq.size(), 3);
    chk("rd_tx0", txq[0], 8'h11);
    chk("rd_tx1", txq[1], 8'h22);
    chk("rd_tx2", txq[2], 8'h06);
    chk("rd_busy_respected", gap_err, 0);
    chk("rd_tx_latency", tx_cyc[0] - ack_cyc[0], 1);

    // Bad field NAKs
    clear();
    send_pkt(64'h41, 1);
    wait_tx(1, 50); settle(20);
    chk("badcmd_byte", txq[0], 8'h15);
    chk("badcmd_latency", tx_cyc[0] - last_rx_cyc, 2);

    clear();
    send_pkt(64'h5708, 2);
    wait_tx(1, 50); settle(20);
    chk("badhi_byte", txq[0], 8'h15);
    chk("badhi_latency", tx_cyc[0] - last_rx_cyc, 2);

    clear();
    send_pkt(64'h57012300, 4);
    wait_tx(1, 50); settle(20);
    chk("len0_byte", txq[0], 8'h15);
    chk("len0_latency", tx_cyc[0] - last_rx_cyc, 2);

    clear();
    send_pkt(64'h57012311, 4);
    wait_tx(1, 50); settle(20);
    chk("len17_byte", txq[0], 8'h15);
    chk("len17_latency", tx_cyc[0] - last_rx_cyc, 2);

    // Maximum length write at 0x7F8, wrapping to 0x007
    clear(); mem_delay = 0;
    s = 8'h57 + 8'h07 + 8'hF8 + 8'h10;
    send_byte(8'h57); send_byte(8'h07); send_byte(8'hF8); send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 7 + 1);
      s = s + d;
      send_byte(d);
    end
    send_byte(8'h00 - s);
    wait_tx(1, 500); settle(20);
    chk("len16_count", memq.size(), 16);
    chk("len16_first", memq[0], {1'b1, 11'h7F8, 8'h01});
    chk("len16_last", memq[15], {1'b1, 11'h007, 8'h6A});
    chk("len16_resp", txq[0], 8'h06);

    // Inter-byte timeout, then recovery
    clear();
    send_byte(8'h57); send_byte(8'h01);
    wait_tx(1, 300);
    chk("tmo_byte", txq[0], 8'h15);
    dly = tx_cyc[0] - last_rx_cyc;
    chk("tmo_window", (dly >= 100 && dly <= 104), 1);
    settle(20);
    clear();
    send_pkt(64'h50B0, 2);
    wait_tx(1, 50); settle(20);
    chk("tmo_ping_count", txq.size(), 1);
    chk("tmo_ping_byte", txq[0], 8'h06);

    // Reset while a request is outstanding
    clear(); mem_delay = 1000;
    send_pkt(64'h57012302AA5584, 7);
    for (int i = 0; i < 20 && !bus.mem_req; i++) @(negedge clk);
    chk("rst_req_seen", bus.mem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_outputs", {2'b0, bus.tx_data, bus.new_tx_data, bus.mem_req, bus.mem_we,
                              bus.mem_addr, bus.mem_wdata}, 32'h0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    mem_delay = 0;
    settle(40);
    chk("rst_no_resp", txq.size(), 0);
    chk("rst_no_write", memq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Host-command framer that sits directly downstream of the UART in the PGM8755 programmer. It consumes received bytes, frames and checksums host packets, and buffers write payloads so nothing reaches memory until the checksum verifies. It then drives a request/acknowledge memory port toward the 8755 programming logic. It returns ACK/NAK status bytes and read data through the UART transmit handshake.

## Interface
Parameters:
- MAX_LEN, 16: maximum payload bytes per packet; also the depth of the internal write buffer.
- TIMEOUT_CYCLES, 5000000: maximum idle clocks allowed between bytes inside a packet (100 ms at 50 MHz).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid only while new_rx_data is high.
- new_rx_data  in  1  one-cycle strobe marking a new received byte.
- tx_busy  in  1  UART transmitter busy.
- tx_data  out  8  byte to transmit.
- new_tx_data  out  1  one-cycle transmit strobe.
- mem_req  out  1  memory request.
- mem_we  out  1  write when 1, read when 0; valid with mem_req.
- mem_addr  out  11  8755 byte address.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data; sampled in the cycle mem_ack is high.
- mem_ack  in  1  completes the current request.

## Operation
- Packet format: CMD, [ADDR_HI, ADDR_LO, LEN, payload…], CSUM.
- Checksum rule: the 8-bit modulo-256 sum of every byte in the packet, including CSUM, must equal 0x00.
- Commands:
  - 'P' (0x50), ping: packet is CMD, CSUM only.
  - 'W' (0x57), write: carries address, LEN, and LEN payload bytes.
  - 'R' (0x52), read: carries address and LEN; no payload.
- Any other CMD byte: send NAK (0x15) immediately and return to IDLE.
- Status bytes: ACK = 0x06, NAK = 0x15.
- Address: {ADDR_HI[2:0], ADDR_LO}.
  - ADDR_HI[7:3] ≠ 0 → send NAK immediately after ADDR_HI.
- Length: LEN = 0 or LEN > MAX_LEN → send NAK immediately after LEN.
- States: IDLE, ADDR_HI, ADDR_LO, LEN, DATA, CSUM, MEM, SEND, RESP.
  - IDLE → ADDR_HI for 'W'/'R'; IDLE → CSUM for 'P'.
  - DATA is entered for 'W' only; a 'R' goes from LEN directly to CSUM.
  - On a bad checksum, NAK is sent and nothing is written to memory.
- Write sequence:
  - CSUM good → MEM.
  - Issue LEN sequential write requests from the buffer.
  - Then RESP sends ACK.
- Read sequence:
  - CSUM good → repeat {MEM read → SEND the captured byte} LEN times.
  - Then RESP sends ACK.
- Address increment: addr + 1 modulo 2048 (0x7FF wraps to 0x000).
- Memory handshake:
  - Raise mem_req with mem_we, mem_addr and mem_wdata set.
  - Hold all of them stable until mem_ack is sampled high.
  - Drop mem_req the following cycle; one request is outstanding at a time.
  - mem_ack is ignored while mem_req is low.
  - There is no memory timeout.
- Transmit handshake:
  - Pulse new_tx_data for one cycle, and only when tx_busy = 0.
  - Ignore tx_busy for the next cycle (guard cycle).
  - Then wait for tx_busy = 0 before the next pulse.
- Inter-byte timeout:
  - A counter runs in ADDR_HI, ADDR_LO, LEN, DATA and CSUM, and clears on each new_rx_data.
  - Reaching TIMEOUT_CYCLES → send NAK and return to IDLE.
- Discarded bytes: new_rx_data in MEM, SEND or RESP is dropped. The next packet starts only after returning to IDLE.

## Timing
- Reset values: tx_data = 0, new_tx_data = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. State = IDLE, timeout counter = 0, buffer contents don't-care.
- Each byte is registered in the cycle of its new_rx_data.
- Checksum evaluation: new_tx_data (ACK/NAK) or mem_req asserts 2 cycles after the CSUM strobe, provided tx_busy = 0.
- Immediate NAKs (bad CMD, bad ADDR_HI, bad LEN) assert new_tx_data 2 cycles after the offending strobe, when tx_busy = 0.
- mem_req asserts 1 cycle after the previous request's ack cycle or the previous SEND completion.
- Read data: new_tx_data for a read byte asserts 1 cycle after its mem_ack, when tx_busy = 0.
- Reset mid-packet or mid-request: all activity aborts, mem_req drops asynchronously, and no response is sent.

## Test plan
- Ping 0x50, 0xB0 → exactly one new_tx_data with tx_data = 0x06; no mem_req.
- Write 0x57 01 23 02 AA 55 84 →
  - writes 0x123 = 0xAA, then 0x124 = 0x55;
  - mem_ack delayed 10 cycles: mem_req, mem_addr and mem_wdata hold stable;
  - then ACK is sent.
- Same write with CSUM 0x85 → NAK; mem_req never asserts.
- Read 0x52 07 FF 02 A6, with the memory model returning 0x11 and 0x22 →
  - read addresses 0x7FF, then 0x000 (wrap);
  - tx bytes 0x11, 0x22, 0x06, each sent only after tx_busy falls.
- Bad-field NAKs:
  - CMD 0x41 → NAK.
  - 'W' with ADDR_HI = 0x08 → NAK after the ADDR_HI byte.
  - 'W' with LEN = 0 → NAK.
  - 'W' with LEN = 17 → NAK.
- Robustness:
  - Stop mid-'W' for TIMEOUT_CYCLES (bench sets it to 100) → NAK, and a following ping gets ACK.
  - Assert rst during MEM → outputs return to 0 immediately.
